// File: rtl/project_pkg.sv
// Shared project types and constants for the register file and its write-back path.
package project_pkg;

  localparam int unsigned WORD_SIZE = 8;
  localparam int unsigned REG_SIZE  = 4;

  typedef logic [WORD_SIZE-1:0]         word;
  typedef logic [$clog2(REG_SIZE)-1:0]  e_reg;

  // Write-back requester slots
  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_MEM = 1;

  localparam int unsigned PEND_MAX_DFLT = 3;
  typedef logic [$clog2(PEND_MAX_DFLT+1)-1:0] sb_cnt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the pointer and wraps modulo NREQ.
module rr_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_raw;
  logic            found;
  int unsigned     idx;
  logic [PtrW-1:0] idx_p;

  always_comb begin
    gnt_raw = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = 0;
    idx_p   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx   = (32'(ptr_q) + k) % NREQ;
      idx_p = PtrW'(idx);
      if (!found && req[idx_p]) begin
        found          = 1'b1;
        gnt_raw[idx_p] = 1'b1;
        ptr_d          = PtrW'((idx + 1) % NREQ);
      end
    end
  end

  // A grant always coincides with a transfer, so the pointer moves on any grant
  assign gnt = rst ? gnt_raw : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (|gnt_raw) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Write-back controller: arbitrates the register file write port and tracks pending writes
// per register so decode can stall on RAW hazards.
module reg_wb_arbiter
  import project_pkg::*;
#(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned PEND_MAX = PEND_MAX_DFLT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  e_reg [NREQ-1:0]     req_addr,
  input  word  [NREQ-1:0]     req_data,
  input  logic                claim_en,
  input  e_reg                claim_addr,
  output logic                claim_ready,
  output logic                rf_wr_en,
  output e_reg                rf_wr_addr,
  output word                 rf_wr_data,
  output logic [REG_SIZE-1:0] busy,
  output logic                sb_err
);

  localparam int unsigned CntW = $clog2(PEND_MAX + 1);
  typedef logic [CntW-1:0] cnt_t;

  logic [NREQ-1:0] gnt;
  e_reg            sel_addr;
  word             sel_data;

  logic            rf_wr_en_q, rf_wr_en_d;
  e_reg            rf_wr_addr_q, rf_wr_addr_d;
  word             rf_wr_data_q, rf_wr_data_d;

  cnt_t            cnt_q [REG_SIZE];
  cnt_t            cnt_d [REG_SIZE];
  logic            sb_err_q, sb_err_d;
  logic [REG_SIZE-1:0] claim_hit, commit_hit;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .gnt (gnt)
  );

  assign req_ready = gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i];
        sel_data = req_data[i];
      end
    end
  end

  // Addr/data hold their last values when nothing is granted
  always_comb begin
    rf_wr_en_d   = |gnt;
    rf_wr_addr_d = rf_wr_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    if (|gnt) begin
      rf_wr_addr_d = sel_addr;
      rf_wr_data_d = sel_data;
    end
  end

  assign claim_ready = (cnt_q[claim_addr] != cnt_t'(PEND_MAX));

  always_comb begin
    claim_hit  = '0;
    commit_hit = '0;
    for (int unsigned r = 0; r < REG_SIZE; r++) begin
      claim_hit[r]  = claim_en && claim_ready && (claim_addr == e_reg'(r));
      commit_hit[r] = rf_wr_en_q && (rf_wr_addr_q == e_reg'(r));
    end
  end

  // A claim and a commit on the same register cancel out
  always_comb begin
    sb_err_d = sb_err_q;
    for (int unsigned r = 0; r < REG_SIZE; r++) begin
      cnt_d[r] = cnt_q[r];
      if (claim_hit[r] && !commit_hit[r]) begin
        cnt_d[r] = cnt_q[r] + cnt_t'(1);
      end else if (commit_hit[r] && !claim_hit[r]) begin
        if (cnt_q[r] == '0) begin
          sb_err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - cnt_t'(1);
        end
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned r = 0; r < REG_SIZE; r++) begin
      busy[r] = (cnt_q[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
      sb_err_q     <= 1'b0;
      for (int unsigned r = 0; r < REG_SIZE; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      sb_err_q     <= sb_err_d;
      for (int unsigned r = 0; r < REG_SIZE; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_addr = rf_wr_addr_q;
  assign rf_wr_data = rf_wr_data_q;
  assign sb_err     = sb_err_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed scenarios plus randomized traffic against a cycle model.
module tb_reg_wb_arbiter;
  import project_pkg::*;

  localparam int NREQ = 2;
  localparam int PMAX = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][1:0]  req_addr;
  logic [NREQ-1:0][7:0]  req_data;
  logic                  claim_en;
  logic [1:0]            claim_addr;
  logic                  claim_ready;
  logic                  rf_wr_en;
  logic [1:0]            rf_wr_addr;
  logic [7:0]            rf_wr_data;
  logic [3:0]            busy;
  logic                  sb_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_ptr;
  int m_cnt [4];
  bit m_err;
  bit m_wr_en;
  int m_addr;
  int m_data;

  logic [7:0] tb_rf [4];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_wr_en === 1'b1) tb_rf[rf_wr_addr] <= rf_wr_data;
  end

  reg_wb_arbiter #(
    .NREQ     (NREQ),
    .PEND_MAX (PMAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .claim_en    (claim_en),
    .claim_addr  (claim_addr),
    .claim_ready (claim_ready),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .busy        (busy),
    .sb_err      (sb_err)
  );

  function automatic int model_grant();
    if (rst !== 1'b1) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ] === 1'b1) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    logic [NREQ-1:0] r;
    int g;
    r = '0;
    g = model_grant();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] exp_busy();
    logic [3:0] b;
    for (int r = 0; r < 4; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  function automatic logic exp_claim_ready();
    return m_cnt[claim_addr] < PMAX;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_err = 0; m_wr_en = 0; m_addr = 0; m_data = 0;
    for (int r = 0; r < 4; r++) m_cnt[r] = 0;
  endtask

  // Advance model and DUT by one clock; returns at the following falling edge
  task automatic tick();
    int  g;
    bit  claim_ok;
    g = model_grant();
    claim_ok = (claim_en === 1'b1) && (m_cnt[claim_addr] < PMAX);
    for (int r = 0; r < 4; r++) begin
      int n;
      n = m_cnt[r] + ((claim_ok && claim_addr == r) ? 1 : 0)
                   - ((m_wr_en && m_addr == r) ? 1 : 0);
      if (n < 0) begin
        m_err = 1;
        n = 0;
      end
      m_cnt[r] = n;
    end
    if (g >= 0) begin
      m_wr_en = 1;
      m_addr  = int'(req_addr[g]);
      m_data  = int'(req_data[g]);
      m_ptr   = (g + 1) % NREQ;
    end else begin
      m_wr_en = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    req_valid = '0;
    claim_en  = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    req_addr = '0; req_data = '0; claim_addr = '0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    req_valid = 2'b11;
    #1;
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", rf_wr_en); end
    checks++; if (rf_wr_addr !== 2'd0 || rf_wr_data !== 8'h00) begin
      errors++; $display("FAIL reset_addr_data got %h/%h want 0/00", rf_wr_addr, rf_wr_data); end
    checks++; if (busy !== 4'b0000 || sb_err !== 1'b0) begin
      errors++; $display("FAIL reset_busy_err got %b/%b want 0000/0", busy, sb_err); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", req_ready); end
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_first_grant got %b want 01", req_ready); end
    req_addr[0] = 2'd1; req_data[0] = 8'h5A;
    claim_en = 1'b1; claim_addr = 2'd2;
    tick();
    set_idle();
    req_valid = 2'b11;
    #3;
    rst = 1'b0;
    #1;
    checks++; if (rf_wr_en !== 1'b0 || busy !== 4'b0000 || sb_err !== 1'b0 || req_ready !== 2'b00) begin
      errors++; $display("FAIL async_reset got en=%b busy=%b err=%b rdy=%b want 0/0000/0/00",
                         rf_wr_en, busy, sb_err, req_ready); end
    model_reset();
    set_idle();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_write();
    do_reset();
    req_valid = 2'b01; req_addr[0] = 2'd2; req_data[0] = 8'hCC;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b want 01", req_ready); end
    tick();
    set_idle();
    checks++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 2'd2 || rf_wr_data !== 8'hCC) begin
      errors++; $display("FAIL single_wr got %b/%h/%h want 1/2/cc", rf_wr_en, rf_wr_addr, rf_wr_data); end
    tick();
    checks++; if (rf_wr_en !== 1'b0 || rf_wr_addr !== 2'd2 || tb_rf[2] !== 8'hCC) begin
      errors++; $display("FAIL single_commit got en=%b addr=%h rf=%h want 0/2/cc", rf_wr_en, rf_wr_addr, tb_rf[2]); end
  endtask

  task automatic test_round_robin();
    logic [7:0] alu [2];
    logic [7:0] mem [2];
    logic [7:0] exp_d [4];
    int ai, mi;
    logic [NREQ-1:0] rdy;
    alu[0] = 8'hAA; alu[1] = 8'hBB; mem[0] = 8'h11; mem[1] = 8'h22;
    exp_d[0] = 8'hAA; exp_d[1] = 8'h11; exp_d[2] = 8'hBB; exp_d[3] = 8'h22;
    ai = 0; mi = 0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      req_valid[REQ_ALU] = (ai < 2); req_addr[REQ_ALU] = 2'd0; req_data[REQ_ALU] = alu[ai % 2];
      req_valid[REQ_MEM] = (mi < 2); req_addr[REQ_MEM] = 2'd1; req_data[REQ_MEM] = mem[mi % 2];
      #1;
      rdy = req_ready;
      checks++; if (rdy !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL rr_grant_%0d got %b want %b", c, rdy, (c % 2 == 0) ? 2'b01 : 2'b10); end
      tick();
      if (rdy[REQ_ALU]) ai++;
      if (rdy[REQ_MEM]) mi++;
      checks++; if (rf_wr_en !== 1'b1 || rf_wr_data !== exp_d[c]) begin
        errors++; $display("FAIL rr_data_%0d got %b/%h want 1/%h", c, rf_wr_en, rf_wr_data, exp_d[c]); end
    end
    set_idle();
    tick();
  endtask

  task automatic test_scoreboard();
    do_reset();
    claim_en = 1'b1; claim_addr = 2'd3;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (claim_ready !== 1'b1) begin errors++; $display("FAIL sb_claim_rdy_%0d got %b want 1", k, claim_ready); end
      tick();
    end
    #1;
    checks++; if (busy[3] !== 1'b1 || claim_ready !== 1'b0) begin
      errors++; $display("FAIL sb_full got busy3=%b rdy=%b want 1/0", busy[3], claim_ready); end
    tick();
    claim_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 2'b10; req_addr[1] = 2'd3; req_data[1] = 8'(k);
      tick();
      set_idle();
      tick();
      checks++; if (busy[3] !== (k < 2)) begin
        errors++; $display("FAIL sb_commit_%0d got busy3=%b want %b", k, busy[3], (k < 2)); end
    end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL sb_no_err got %b want 0", sb_err); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    claim_en = 1'b1; claim_addr = 2'd1;
    tick();
    claim_en = 1'b0;
    req_valid = 2'b01; req_addr[0] = 2'd1; req_data[0] = 8'h77;
    tick();
    set_idle();
    claim_en = 1'b1; claim_addr = 2'd1;
    tick();
    claim_en = 1'b0;
    checks++; if (busy[1] !== 1'b1) begin errors++; $display("FAIL same_cycle_busy got %b want 1", busy[1]); end
    req_valid = 2'b01;
    tick();
    set_idle();
    tick();
    checks++; if (busy[1] !== 1'b0 || sb_err !== 1'b0) begin
      errors++; $display("FAIL same_cycle_clear got busy1=%b err=%b want 0/0", busy[1], sb_err); end
  endtask

  task automatic test_error();
    do_reset();
    req_valid = 2'b01; req_addr[0] = 2'd0; req_data[0] = 8'h01;
    tick();
    set_idle();
    tick();
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", sb_err); end
    for (int k = 0; k < 4; k++) begin
      claim_en = 1'b1; claim_addr = 2'd2;
      req_valid = 2'b10; req_addr[1] = 2'd2; req_data[1] = 8'(k);
      tick();
    end
    set_idle();
    tick();
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", sb_err); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL err_reset got %b want 0", sb_err); end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_random();
    bit pend [NREQ];
    int g;
    do_reset();
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1;
          req_addr[i] = 2'($urandom_range(0, 3));
          req_data[i] = 8'($urandom);
        end
        req_valid[i] = pend[i];
      end
      claim_en   = ($urandom_range(0, 3) != 0);
      claim_addr = 2'($urandom_range(0, 3));
      #1;
      checks++; if (req_ready !== exp_ready()) begin
        errors++; $display("FAIL rnd_ready c=%0d got %b want %b", c, req_ready, exp_ready()); end
      checks++; if (claim_ready !== exp_claim_ready() || busy !== exp_busy()) begin
        errors++; $display("FAIL rnd_sb c=%0d got rdy=%b busy=%b want %b/%b",
                           c, claim_ready, busy, exp_claim_ready(), exp_busy()); end
      g = model_grant();
      tick();
      if (g >= 0) pend[g] = 0;
      checks++; if (rf_wr_en !== m_wr_en || rf_wr_addr !== 2'(m_addr) || rf_wr_data !== 8'(m_data)) begin
        errors++; $display("FAIL rnd_wr c=%0d got %b/%h/%h want %b/%h/%h", c, rf_wr_en, rf_wr_addr,
                           rf_wr_data, m_wr_en, 2'(m_addr), 8'(m_data)); end
      checks++; if (sb_err !== m_err) begin
        errors++; $display("FAIL rnd_err c=%0d got %b want %b", c, sb_err, m_err); end
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_scoreboard();
    test_same_cycle();
    test_error();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
